// File: rtl/rotary_emulator.sv
// Quadrature rotary-encoder emulator. It turns valid/ready commands into full
// detent sequences on Rot_A/Rot_B, or push pulses on Rot_C, for the rotary decoder.
module rotary_emulator #(
  parameter int unsigned PHASE_CYCLES = 100,
  parameter int unsigned GAP_CYCLES   = 200,
  parameter int unsigned PRESS_CYCLES = 1
) (
  input  logic       Fg_CLK,
  input  logic       RESETn,
  input  logic       Cmd_Valid,
  input  logic [1:0] Cmd_Type,
  input  logic [7:0] Cmd_Count,
  output logic       Cmd_Ready,
  output logic       Rot_A,
  output logic       Rot_B,
  output logic       Rot_C,
  output logic       Done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PH0, S_PH1, S_PH2, S_PH3, S_PRESS, S_GAP, S_NOP
  } state_e;

  localparam logic [15:0] P_LOAD = 16'(PHASE_CYCLES - 1);
  localparam logic [15:0] W_LOAD = 16'(PRESS_CYCLES - 1);
  localparam logic [15:0] G_LOAD = 16'(GAP_CYCLES - 1);
  // PH3 already spends one rest cycle, so the gap that follows a detent is one shorter.
  localparam logic [15:0] G3_LOAD = (GAP_CYCLES > 1) ? 16'(GAP_CYCLES - 2) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rep_q, rep_d;
  logic        minus_q, minus_d;
  logic        press_q, press_d;
  logic        a_q, a_d, b_q, b_d, c_q, c_d;
  logic        done_q, done_d;
  logic        cnt_zero, start_rep, finish;

  // {A,B} after the given edge (0..3) of a detent.
  function automatic logic [1:0] detent_ab(input logic minus, input logic [1:0] idx);
    case (idx)
      2'd0:    detent_ab = minus ? 2'b01 : 2'b10;
      2'd1:    detent_ab = 2'b00;
      2'd2:    detent_ab = minus ? 2'b10 : 2'b01;
      default: detent_ab = 2'b11;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    minus_d   = minus_q;
    press_d   = press_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    done_d    = 1'b0;
    start_rep = 1'b0;
    finish    = 1'b0;
    cnt_zero  = (cnt_q == 16'd0);

    unique case (state_q)
      S_IDLE: begin
        if (Cmd_Valid) begin
          if (Cmd_Type == 2'b11 || Cmd_Count == 8'd0) begin
            state_d = S_NOP;
          end else begin
            minus_d   = Cmd_Type[0];
            press_d   = Cmd_Type[1];
            rep_d     = Cmd_Count - 8'd1;
            start_rep = 1'b1;
          end
        end
      end
      S_PH0: begin
        if (cnt_zero) begin
          state_d    = S_PH1;
          cnt_d      = P_LOAD;
          {a_d, b_d} = detent_ab(minus_q, 2'd1);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PH1: begin
        if (cnt_zero) begin
          state_d    = S_PH2;
          cnt_d      = P_LOAD;
          {a_d, b_d} = detent_ab(minus_q, 2'd2);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PH2: begin
        if (cnt_zero) begin
          state_d    = S_PH3;
          cnt_d      = 16'd0;
          {a_d, b_d} = detent_ab(minus_q, 2'd3);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PH3: begin
        if (GAP_CYCLES > 1) begin
          state_d = S_GAP;
          cnt_d   = G3_LOAD;
        end else begin
          finish = 1'b1;
        end
      end
      S_PRESS: begin
        if (cnt_zero) begin
          state_d = S_GAP;
          cnt_d   = G_LOAD;
          c_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_zero) finish = 1'b1;
        else          cnt_d  = cnt_q - 16'd1;
      end
      S_NOP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      if (rep_q == 8'd0) begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        done_d  = 1'b1;
      end else begin
        rep_d     = rep_q - 8'd1;
        start_rep = 1'b1;
      end
    end

    // The first pin edge of every repetition lands on the edge that starts it.
    if (start_rep) begin
      if (press_d) begin
        state_d = S_PRESS;
        cnt_d   = W_LOAD;
        c_d     = 1'b1;
      end else begin
        state_d    = S_PH0;
        cnt_d      = P_LOAD;
        {a_d, b_d} = detent_ab(minus_d, 2'd0);
      end
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      rep_q   <= 8'd0;
      minus_q <= 1'b0;
      press_q <= 1'b0;
      a_q     <= 1'b1;
      b_q     <= 1'b1;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      minus_q <= minus_d;
      press_q <= press_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign Cmd_Ready = (state_q == S_IDLE);
  assign Rot_A     = a_q;
  assign Rot_B     = b_q;
  assign Rot_C     = c_q;
  assign Done      = done_q;

endmodule
